// File: rtl/shifter_pkg.sv
// -----------------------------------------------------------------------------
// shifter_pkg
// Shared types for the pipelined barrel shifter:
//   shift_op_e        - 2-bit shift operation (value 3 is reserved, acts as ROT)
//   shifter_payload_t - everything one pipeline stage carries to the next
// The payload is sized for the widest supported shifter (SHIFTER_MAX_N); a
// narrower instance uses only the low N data bits and the low AW amount bits,
// and the unused upper bits stay zero.
// -----------------------------------------------------------------------------
package shifter_pkg;

  localparam int unsigned SHIFTER_MAX_N  = 64;
  localparam int unsigned SHIFTER_MAX_AW = 7;

  typedef enum logic [1:0] {
    SHIFT_ROT     = 2'd0,
    SHIFT_LSL_LSR = 2'd1,
    SHIFT_ASR     = 2'd2
  } shift_op_e;

  typedef struct packed {
    logic [SHIFTER_MAX_N-1:0]  data;
    shift_op_e                 op;
    logic                      direction;
    logic [SHIFTER_MAX_AW-1:0] amount;
    logic                      saturate;
    logic                      valid;
  } shifter_payload_t;

  // The reserved encoding falls back to rotate, so "rotate" is simply
  // "neither of the two fill-based operations".
  function automatic logic op_is_rotate(input shift_op_e op);
    return !((op == SHIFT_LSL_LSR) || (op == SHIFT_ASR));
  endfunction

endpackage

// File: rtl/shifter_stage.sv
// -----------------------------------------------------------------------------
// shifter_stage
// One level of the barrel shifter: shifts the payload data by 2^K when amount
// bit K is set, then registers the whole payload while advance_i is high.
// Stage 0 additionally resolves the "amount >= N" flag and applies saturation.
// Ports:
//   clk_i, rst_ni  - clock, asynchronous active-low reset
//   advance_i      - global pipeline enable (low = hold, including bubbles)
//   payload_i      - payload from the previous stage (or the input port)
//   payload_d_o    - next-state payload (what the register will load)
//   payload_q_o    - registered payload towards the next stage
// -----------------------------------------------------------------------------
module shifter_stage
  import shifter_pkg::*;
#(
  parameter int unsigned N = 8,
  parameter int unsigned K = 0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             advance_i,
  input  shifter_payload_t payload_i,
  output shifter_payload_t payload_d_o,
  output shifter_payload_t payload_q_o
);

  localparam int unsigned D  = 1 << K;
  localparam int unsigned AW = $clog2(N) + 1;

  shifter_payload_t shifted;
  shifter_payload_t payload_d;
  shifter_payload_t payload_q;
  logic [N-1:0]     din;
  logic [N-1:0]     dout;
  logic             sat;
  logic             fill;
  logic             is_rot;

  // Shift by 2^K. An oversized logical/arithmetic shift is turned into its
  // final value up front in stage 0; the later stages then leave an all-zero
  // or all-sign word unchanged, so no extra logic is needed at the tail.
  always_comb begin
    shifted = payload_i;
    is_rot  = op_is_rotate(payload_i.op);
    sat     = payload_i.saturate;
    if (K == 0) sat = payload_i.amount[AW-1];
    din = payload_i.data[N-1:0];
    if (sat && !is_rot) begin
      if ((payload_i.op == SHIFT_ASR) && !payload_i.direction) din = {N{payload_i.data[N-1]}};
      else din = '0;
    end
    fill = ((payload_i.op == SHIFT_ASR) && !payload_i.direction) ? din[N-1] : 1'b0;
    dout = din;
    if (payload_i.amount[K]) begin
      if (payload_i.direction) begin
        if (is_rot) dout = {din[N-1-D:0], din[N-1:N-D]};
        else        dout = {din[N-1-D:0], {D{1'b0}}};
      end else begin
        if (is_rot) dout = {din[D-1:0], din[N-1:D]};
        else        dout = {{D{fill}}, din[N-1:D]};
      end
    end
    shifted.data[N-1:0] = dout;
    shifted.saturate    = sat;
  end

  always_comb begin
    payload_d = payload_q;
    if (advance_i) payload_d = shifted;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) payload_q <= '0;
    else         payload_q <= payload_d;
  end

  assign payload_d_o = payload_d;
  assign payload_q_o = payload_q;

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// -----------------------------------------------------------------------------
// pipelined_barrel_shifter
// Pipelined N-bit barrel shifter (rotate / logical / arithmetic) with one
// register per shift level and valid/ready handshaking through a global stall.
// Latency is $clog2(N) cycles, throughput one word per cycle.
// Ports:
//   clk_i, rst_ni             - clock, asynchronous active-low reset
//   valid_i, ready_o          - input handshake
//   data_i                    - operand
//   shift_amount_i            - distance 0..2N-1 (top bit = "at least N")
//   shift_direction_i         - 1 = left, 0 = right
//   shift_op_i                - shift_op_e encoding (3 behaves as rotate)
//   valid_o, ready_i          - output handshake
//   shifted_data_o            - result
//   zero_o                    - result is all zeros (only with the macro below)
// Build option: define SHIFTER_ZERO_FLAG_EN to add the zero_o flag.
// -----------------------------------------------------------------------------
module pipelined_barrel_shifter
  import shifter_pkg::*;
#(
  parameter int unsigned N  = 8,
  parameter int unsigned AW = $clog2(N) + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          valid_i,
  output logic          ready_o,
  input  logic [N-1:0]  data_i,
  input  logic [AW-1:0] shift_amount_i,
  input  logic          shift_direction_i,
  input  logic [1:0]    shift_op_i,
  output logic          valid_o,
  input  logic          ready_i,
`ifdef SHIFTER_ZERO_FLAG_EN
  output logic          zero_o,
`endif
  output logic [N-1:0]  shifted_data_o
);

  localparam int unsigned S = $clog2(N);

  shifter_payload_t in_payload;
  shifter_payload_t pipe   [S+1];
  shifter_payload_t pipe_d [S];
  logic             advance;
  logic             unused_tail;

  // Pack the input port into a payload. When the pipe is stalled the first
  // stage does not load, so valid_i needs no gating with ready_o here.
  always_comb begin
    in_payload                   = '0;
    in_payload.data[N-1:0]       = data_i;
    in_payload.amount[AW-1:0]    = shift_amount_i;
    in_payload.op                = shift_op_e'(shift_op_i);
    in_payload.direction         = shift_direction_i;
    in_payload.valid             = valid_i;
  end

  assign pipe[0] = in_payload;

  for (genvar k = 0; k < S; k++) begin : g_stage
    logic unused_d;

    shifter_stage #(
      .N (N),
      .K (k)
    ) u_stage (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .advance_i   (advance),
      .payload_i   (pipe[k]),
      .payload_d_o (pipe_d[k]),
      .payload_q_o (pipe[k+1])
    );

    assign unused_d = ^pipe_d[k];
  end

  // Whole pipe moves together; an empty output slot or a willing consumer
  // lets everything, bubbles included, step forward.
  assign valid_o        = pipe[S].valid;
  assign shifted_data_o = pipe[S].data[N-1:0];
  assign advance        = ~valid_o | ready_i;
  assign ready_o        = advance;
  assign unused_tail    = ^pipe[S];

`ifdef SHIFTER_ZERO_FLAG_EN
  logic zero_d;
  logic zero_q;

  // The last stage's next-state already reflects the hold, so the flag
  // simply tracks it and stays aligned with shifted_data_o.
  always_comb begin
    zero_d = pipe_d[S-1].valid & ~|pipe_d[S-1].data[N-1:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) zero_q <= 1'b0;
    else         zero_q <= zero_d;
  end

  assign zero_o = zero_q;
`endif

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// -----------------------------------------------------------------------------
// tb_pipelined_barrel_shifter
// Self-checking bench for the N=8 pipelined barrel shifter. Expected results
// are pushed into a queue when a word is accepted and popped when the DUT
// hands a result over.
// -----------------------------------------------------------------------------
module tb_pipelined_barrel_shifter;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b1;
  logic       valid_i = 1'b0;
  logic       ready_o;
  logic [7:0] data_i = '0;
  logic [3:0] shift_amount_i = '0;
  logic       shift_direction_i = 1'b0;
  logic [1:0] shift_op_i = '0;
  logic       valid_o;
  logic       ready_i = 1'b1;
  logic [7:0] shifted_data_o;
`ifdef SHIFTER_ZERO_FLAG_EN
  logic       zero_o;
`endif

  int         total = 0;
  int         bad = 0;
  int         cycle = 0;
  logic [7:0] expQ[$];
  int         accQ[$];
  logic       holdPending = 1'b0;
  logic [7:0] heldData = '0;
  logic       checkLat = 1'b0;
  logic       lastAccepted = 1'b0;
  int         accCount;
  int         guard;
  logic [7:0] rData;
  logic [3:0] rAmt;
  logic       rDir;
  logic [1:0] rOp;
  logic       rV;
  logic       rRdy;

  pipelined_barrel_shifter #(.N(8)) dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .valid_i           (valid_i),
    .ready_o           (ready_o),
    .data_i            (data_i),
    .shift_amount_i    (shift_amount_i),
    .shift_direction_i (shift_direction_i),
    .shift_op_i        (shift_op_i),
    .valid_o           (valid_o),
    .ready_i           (ready_i),
`ifdef SHIFTER_ZERO_FLAG_EN
    .zero_o            (zero_o),
`endif
    .shifted_data_o    (shifted_data_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: bench still running at time %0t, limit 500000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference shifter, written directly from the operation rules.
  function automatic logic [7:0] refShift(input logic [7:0] d, input logic [3:0] amt,
                                          input logic dir, input logic [1:0] op);
    logic signed [7:0] sd;
    logic [7:0]        res;
    int                r;
    sd = d;
    if (op == 2'd1 || op == 2'd2) begin
      if (amt >= 4'd8)        res = (op == 2'd2 && !dir) ? {8{d[7]}} : 8'h00;
      else if (dir)           res = d << amt;
      else if (op == 2'd2)    res = sd >>> amt;
      else                    res = d >> amt;
    end else begin
      r = int'(amt) % 8;
      if (r == 0)   res = d;
      else if (dir) res = (d << r) | (d >> (8 - r));
      else          res = (d >> r) | (d << (8 - r));
    end
    return res;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, actual, expected, cycle);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, then observe the
  // handshake half a period away from the rising edge and run the scoreboard.
  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic [3:0] amt,
                               input logic dir, input logic [1:0] op, input logic rdy,
                               input int expOverride);
    logic [7:0] e;
    int         ac;
    @(negedge clk_i);
    valid_i = v;
    data_i = d;
    shift_amount_i = amt;
    shift_direction_i = dir;
    shift_op_i = op;
    ready_i = rdy;
    #1;
    cycle++;
    lastAccepted = 1'b0;
    if (holdPending) begin
      checkOutput("hold_valid", 32'(valid_o), 32'd1);
      checkOutput("hold_data", 32'(shifted_data_o), 32'(heldData));
`ifdef SHIFTER_ZERO_FLAG_EN
      checkOutput("hold_zero", 32'(zero_o), 32'(heldData == 8'h00));
`endif
      holdPending = 1'b0;
    end
    if (valid_o && ready_i) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_out", 32'(valid_o), 32'd0);
      end else begin
        e = expQ.pop_front();
        ac = accQ.pop_front();
        checkOutput("data", 32'(shifted_data_o), 32'(e));
`ifdef SHIFTER_ZERO_FLAG_EN
        checkOutput("zero", 32'(zero_o), 32'(e == 8'h00));
`endif
        if (checkLat) checkOutput("latency", 32'(cycle - ac), 32'd3);
      end
    end else if (valid_o) begin
      holdPending = 1'b1;
      heldData = shifted_data_o;
    end
    if (v && ready_o) begin
      expQ.push_back(expOverride < 0 ? refShift(d, amt, dir, op) : 8'(expOverride));
      accQ.push_back(cycle);
      lastAccepted = 1'b1;
    end
  endtask

  task automatic drainPipe();
    int g;
    g = 0;
    while (expQ.size() > 0 && g < 50) begin
      applyStimulus(1'b0, 8'h00, 4'd0, 1'b0, 2'd0, 1'b1, -1);
      g++;
    end
    checkOutput("drain_empty", 32'(expQ.size()), 32'd0);
  endtask

  initial begin
    logic [7:0] dirData [8] = '{8'h81, 8'h81, 8'hA5, 8'hA5, 8'hA5, 8'h90, 8'h50, 8'h90};
    logic [3:0] dirAmt  [8] = '{4'd1, 4'd1, 4'd9, 4'd9, 4'd9, 4'd2, 4'd2, 4'd2};
    logic       dirDir  [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [1:0] dirOp   [8] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd0, 2'd2, 2'd2, 2'd2};
    int         dirExp  [8] = '{'hC0, 'h03, 'h00, 'hFF, 'hD2, 'hE4, 'h14, 'h40};
    logic [7:0] stallData [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

    // Reset state
    #3 rst_ni = 1'b0;
    #1;
    checkOutput("reset_valid", 32'(valid_o), 32'd0);
    checkOutput("reset_data", 32'(shifted_data_o), 32'd0);
    checkOutput("reset_ready", 32'(ready_o), 32'd1);
`ifdef SHIFTER_ZERO_FLAG_EN
    checkOutput("reset_zero", 32'(zero_o), 32'd0);
`endif
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Directed cases from the rotate / saturation / arithmetic groups
    checkLat = 1'b1;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, dirData[i], dirAmt[i], dirDir[i], dirOp[i], 1'b1, dirExp[i]);
      repeat (3) applyStimulus(1'b0, 8'h00, 4'd0, 1'b0, 2'd0, 1'b1, -1);
    end
    checkOutput("directed_empty", 32'(expQ.size()), 32'd0);

    // Back-to-back stream at full throughput
    for (int i = 0; i < 6; i++) begin
      rData = 8'($urandom_range(0, 255));
      rAmt = 4'($urandom_range(0, 15));
      rDir = 1'($urandom_range(0, 1));
      rOp = 2'($urandom_range(0, 3));
      applyStimulus(1'b1, rData, rAmt, rDir, rOp, 1'b1, -1);
    end
    drainPipe();
    checkLat = 1'b0;

    // Random back-pressure on the output, random gaps on the input
    accCount = 0;
    guard = 0;
    while (accCount < 8 && guard < 300) begin
      rV = ($urandom_range(0, 3) != 0);
      rRdy = 1'($urandom_range(0, 1));
      rData = 8'($urandom_range(0, 255));
      rAmt = 4'($urandom_range(0, 15));
      rDir = 1'($urandom_range(0, 1));
      rOp = 2'($urandom_range(0, 3));
      applyStimulus(rV, rData, rAmt, rDir, rOp, rRdy, -1);
      if (lastAccepted) accCount++;
      guard++;
    end
    checkOutput("random_accepted", 32'(accCount), 32'd8);
    drainPipe();

    // Stall from the start: only three words fit before the pipe blocks
    accCount = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, stallData[accCount < 5 ? accCount : 4], 4'd1, 1'b1, 2'd1, 1'b0, -1);
      if (lastAccepted) accCount++;
    end
    checkOutput("stall_accepted", 32'(accCount), 32'd3);
    checkOutput("stall_ready", 32'(ready_o), 32'd0);
    checkOutput("stall_valid", 32'(valid_o), 32'd1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 8'h00, 4'd0, 1'b0, 2'd0, 1'b1, -1);
      checkOutput("resume_valid", 32'(valid_o), 32'd1);
    end
    drainPipe();

    // Reset with three words in flight
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 8'h0F + 8'(i), 4'd3, 1'b0, 2'd2, 1'b1, -1);
    end
    @(negedge clk_i);
    valid_i = 1'b0;
    #2 rst_ni = 1'b0;
    #1;
    checkOutput("midrst_valid", 32'(valid_o), 32'd0);
    checkOutput("midrst_data", 32'(shifted_data_o), 32'd0);
    checkOutput("midrst_ready", 32'(ready_o), 32'd1);
    expQ.delete();
    accQ.delete();
    holdPending = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 8'h00, 4'd0, 1'b0, 2'd0, 1'b1, -1);
      checkOutput("post_rst_valid", 32'(valid_o), 32'd0);
    end

    // Pipe still works after the reset
    applyStimulus(1'b1, 8'h3C, 4'd4, 1'b1, 2'd0, 1'b1, 'hC3);
    drainPipe();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
